// File: rtl/ro_sweep_ctrl.sv
// ro_sweep_ctrl: sweeps masked ring oscillators one at a time, counting synchronized edges over a gate window.
module ro_sweep_ctrl #(
  parameter int N_RO       = 4,
  parameter int CNT_W      = 16,
  parameter int GATE_W     = 16,
  parameter int SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_RO-1:0]   ro_mask,
  input  logic [GATE_W-1:0] gate_len,
  output logic [N_RO-1:0]   ring_en,
  input  logic [N_RO-1:0]   ring_out,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [4:0]        res_idx,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_ovf,
  output logic              done
);
  localparam int IW = (N_RO > 1) ? $clog2(N_RO) : 1;
  localparam int TW = (GATE_W > $clog2(SETTLE_CYC) + 1) ? GATE_W : $clog2(SETTLE_CYC) + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, REPORT} state_t;

  state_t            state, state_nx;
  logic [1:0]        rst_q;
  logic              arst;
  logic [N_RO-1:0]   s1, s2, s3, rise;
  logic [N_RO-1:0]   mask_q;
  logic [GATE_W-1:0] gate_q;
  logic [TW-1:0]     tmr;
  logic [IW-1:0]     idx, idx_nx, first, nxt;
  logic              has_nxt, load, adv;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) rst_q <= 2'b11;
    else     rst_q <= {rst_q[0], 1'b0};

  assign arst = rst_q[1];

  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= ring_out;
      s2 <= s1;
      s3 <= s2;
    end

  assign rise    = s2 & ~s3;
  assign res_idx = 5'(idx);

  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    first   = '0;
    nxt     = '0;
    has_nxt = 1'b0;
    for (int i = N_RO - 1; i >= 0; i--) begin
      if (ro_mask[i]) first = IW'(i);
      if (mask_q[i] && IW'(i) > idx) begin
        nxt     = IW'(i);
        has_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    load     = state == IDLE && start && |ro_mask;
    adv      = state == REPORT && res_ready;
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = load ? SETTLE : IDLE;
      SETTLE:  state_nx = tmr == TW'(SETTLE_CYC - 1) ? GATE : SETTLE;
      GATE:    state_nx = tmr == TW'(gate_q - 1'b1) ? REPORT : GATE;
      REPORT:  state_nx = adv ? (has_nxt ? SETTLE : IDLE) : REPORT;
      default: state_nx = IDLE;
    endcase
    idx_nx = load ? first : (adv && has_nxt) ? nxt : idx;
  end

  always_ff @(posedge clk or posedge arst)
    if (arst) state <= IDLE;
    else      state <= state_nx;

  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      tmr       <= '0;
      idx       <= '0;
      mask_q    <= '0;
      gate_q    <= '0;
      ring_en   <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_ovf   <= 1'b0;
      done      <= 1'b0;
    end else begin
      tmr       <= (state_nx != state) ? '0 : tmr + 1'b1;
      idx       <= idx_nx;
      ring_en   <= (state_nx == SETTLE || state_nx == GATE) ? N_RO'(1) << idx_nx : '0;
      res_valid <= state_nx == REPORT;
      done      <= (state == IDLE && start && !(|ro_mask)) || (adv && !has_nxt);
      if (load) begin
        mask_q <= ro_mask;
        gate_q <= (gate_len == '0) ? GATE_W'(1) : gate_len;
        busy   <= 1'b1;
      end
      if (adv && !has_nxt) busy <= 1'b0;
      if (state == SETTLE) begin
        res_count <= '0;
        res_ovf   <= 1'b0;
      end else if (state == GATE && rise[idx]) begin
        if (&res_count) res_ovf <= 1'b1;
        else            res_count <= res_count + 1'b1;
      end
    end
endmodule
